// File: rtl/gnw_pkg.sv
// gnw_pkg
// Shared types and constants for the SDRAM arbiter slice.
//   arb_state_t          : arbiter FSM state encoding
//   GNW_AW               : default byte address width (requesters and SDRAM)
//   GNW_RD_TIMEOUT_DATA  : byte returned to the renderer when a read times out
package gnw_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_GUARD,
        ARB_WAIT
    } arb_state_t;

    localparam int GNW_AW = 25;

    localparam logic [7:0] GNW_RD_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/gnw_sdram_arbiter_if.sv
// gnw_sdram_arbiter_if
// Bundles the loader, renderer and SDRAM-controller signals around the arbiter.
//   slave  modport : the arbiter's view (requests and sd_dout/sd_ready in,
//                    commands, read data and status out)
//   master modport : the surrounding glue's view (the reverse directions)
// Loader   : ld_wr, ld_addr, ld_data -> ; <- ld_wait
// Renderer : rd_req, rd_addr -> ; <- rd_data, rd_valid
// SDRAM    : <- sd_addr, sd_din, sd_rd, sd_we ; sd_dout, sd_ready ->
// Status   : <- err_timeout (sticky)
interface gnw_sdram_arbiter_if
    import gnw_pkg::*;
#(
    parameter int AW = GNW_AW
);

    logic          ld_wr;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_wait;

    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          rd_valid;

    logic [AW-1:0] sd_addr;
    logic [7:0]    sd_din;
    logic          sd_rd;
    logic          sd_we;
    logic [7:0]    sd_dout;
    logic          sd_ready;

    logic          err_timeout;

    modport slave (
        input  ld_wr, ld_addr, ld_data, rd_req, rd_addr, sd_dout, sd_ready,
        output ld_wait, rd_data, rd_valid, sd_addr, sd_din, sd_rd, sd_we,
               err_timeout
    );

    modport master (
        output ld_wr, ld_addr, ld_data, rd_req, rd_addr, sd_dout, sd_ready,
        input  ld_wait, rd_data, rd_valid, sd_addr, sd_din, sd_rd, sd_we,
               err_timeout
    );

endinterface

// File: rtl/gnw_wr_buf.sv
// gnw_wr_buf
// One-entry holding register for loader writes.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr          : loader write strobe; captures addr/data when the slot is free
//   addr, data  : loader address/byte
//   pop         : high in the cycle the buffered write goes out to SDRAM
//   full        : slot occupied (registered; doubles as ld_wait)
//   buf_addr    : buffered address
//   buf_data    : buffered byte
module gnw_wr_buf
    import gnw_pkg::*;
#(
    parameter int AW = GNW_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    data,
    input  logic          pop,
    output logic          full,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_data
);

    // A write arriving in the pop cycle refills the slot straight away, so the
    // buffer stays full; a write against a full, non-popping slot is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (wr && (!full || pop)) begin
            full     <= 1'b1;
            buf_addr <= addr;
            buf_data <= data;
        end else if (pop) begin
            full     <= 1'b0;
        end
    end

    // The loader must honour ld_wait; a strobe into a full slot would be lost.
    a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr && full && !pop));

endmodule

// File: rtl/gnw_sdram_arbiter.sv
// gnw_sdram_arbiter
// Shares the 8-bit SDRAM port between the ROM loader (writes) and the LCD
// renderer (reads). One access at a time: IDLE -> ISSUE -> GUARD -> WAIT.
//   clk_sys     : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   bus         : gnw_sdram_arbiter_if.slave (loader, renderer, SDRAM, status)
// Parameters:
//   AW          : byte address width
//   MAX_WR_RUN  : back-to-back loader writes allowed before a waiting read wins
//   TIMEOUT     : WAIT cycles without sd_ready before the access is abandoned
module gnw_sdram_arbiter
    import gnw_pkg::*;
#(
    parameter int AW         = GNW_AW,
    parameter int MAX_WR_RUN = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    gnw_sdram_arbiter_if.slave bus
);

    localparam int RW = $clog2(MAX_WR_RUN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_WR_RUN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    arb_state_t    state;
    logic [RW-1:0] run;
    logic [TW-1:0] tmo;
    logic          op_is_rd;

    logic          buf_full;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;

    logic          rd_ok;
    logic          grant_rd;
    logic          grant_wr;

    gnw_wr_buf #(
        .AW (AW)
    ) u_wr_buf (
        .clk      (clk_sys),
        .rst_n    (reset_n),
        .wr       (bus.ld_wr),
        .addr     (bus.ld_addr),
        .data     (bus.ld_data),
        .pop      (bus.sd_we),
        .full     (buf_full),
        .buf_addr (buf_addr),
        .buf_data (buf_data)
    );

    assign bus.ld_wait = buf_full;

    // rd_req is still high in its own rd_valid cycle (the renderer drops it in
    // response), so that cycle must not count as a fresh read request.
    assign rd_ok    = bus.rd_req && !bus.rd_valid;
    assign grant_rd = rd_ok && (!buf_full || (run == RUN_MAX));
    assign grant_wr = buf_full && !grant_rd;

    // Sequencer. Command strobes and rd_valid default low each cycle so they
    // are single-cycle pulses; sd_addr/sd_din only change on a grant.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ARB_IDLE;
            run             <= '0;
            tmo             <= '0;
            op_is_rd        <= 1'b0;
            bus.sd_addr     <= '0;
            bus.sd_din      <= '0;
            bus.sd_rd       <= 1'b0;
            bus.sd_we       <= 1'b0;
            bus.rd_data     <= '0;
            bus.rd_valid    <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.sd_rd    <= 1'b0;
            bus.sd_we    <= 1'b0;
            bus.rd_valid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (bus.sd_ready && grant_rd) begin
                        bus.sd_addr <= bus.rd_addr;
                        bus.sd_rd   <= 1'b1;
                        op_is_rd    <= 1'b1;
                        run         <= '0;
                        state       <= ARB_ISSUE;
                    end else if (bus.sd_ready && grant_wr) begin
                        bus.sd_addr <= buf_addr;
                        bus.sd_din  <= buf_data;
                        bus.sd_we   <= 1'b1;
                        op_is_rd    <= 1'b0;
                        if (run != RUN_MAX) begin
                            run <= run + RW'(1);
                        end
                        state       <= ARB_ISSUE;
                    end else if (!bus.rd_req && !buf_full) begin
                        run <= '0;
                    end
                end
                ARB_ISSUE: begin
                    state <= ARB_GUARD;
                end
                ARB_GUARD: begin
                    // sd_ready may still show the pre-command idle level here.
                    tmo   <= '0;
                    state <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (bus.sd_ready) begin
                        if (op_is_rd) begin
                            bus.rd_data  <= bus.sd_dout;
                            bus.rd_valid <= 1'b1;
                        end
                        state <= ARB_IDLE;
                    end else if (tmo == TMO_LAST) begin
                        // Abandon the access; a read still completes so the
                        // renderer is never left waiting forever.
                        bus.err_timeout <= 1'b1;
                        if (op_is_rd) begin
                            bus.rd_data  <= GNW_RD_TIMEOUT_DATA;
                            bus.rd_valid <= 1'b1;
                        end
                        state <= ARB_IDLE;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gnw_sdram_arbiter.sv
// tb_gnw_sdram_arbiter
// Self-checking bench for gnw_sdram_arbiter with a small SDRAM controller model
// and scoreboard queues for writes, read commands and read data.
module tb_gnw_sdram_arbiter;
    import gnw_pkg::*;

    localparam int AW      = 25;
    localparam int MAX_RUN = 8;
    localparam int TMO     = 255;
    localparam int LAT     = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    logic hang    = 1'b0;

    int errors = 0;
    int checks = 0;
    int we_seen = 0;
    int rd_seen = 0;
    int valid_seen = 0;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rdcmd[$];
    logic [7:0]    exp_rdata[$];
    wr_t           mon_w;
    logic [AW-1:0] mon_a;
    logic [7:0]    mon_d;

    int            busy;
    logic          pend_rd;
    logic [AW-1:0] pend_addr;

    always #5 clk_sys = ~clk_sys;

    gnw_sdram_arbiter_if #(.AW(AW)) bus ();

    gnw_sdram_arbiter #(
        .AW         (AW),
        .MAX_WR_RUN (MAX_RUN),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Contents the SDRAM model returns for a read of address a.
    function automatic logic [7:0] model_byte(input logic [AW-1:0] a);
        if (a == AW'('h123)) return 8'h5A;
        return a[7:0] ^ 8'h3C;
    endfunction

    // SDRAM controller model: ready drops after a command and returns LAT
    // cycles later with read data; 'hang' freezes it busy.
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bus.sd_ready <= 1'b1;
            bus.sd_dout  <= 8'h00;
            busy         <= 0;
            pend_rd      <= 1'b0;
            pend_addr    <= '0;
        end else if (bus.sd_rd || bus.sd_we) begin
            bus.sd_ready <= 1'b0;
            busy         <= LAT;
            pend_rd      <= bus.sd_rd;
            pend_addr    <= bus.sd_addr;
        end else if (busy != 0 && !hang) begin
            if (busy == 1) begin
                bus.sd_ready <= 1'b1;
                busy         <= 0;
                if (pend_rd) bus.sd_dout <= model_byte(pend_addr);
            end else begin
                busy <= busy - 1;
            end
        end
    end

    // Scoreboard: every command and read completion is matched against the
    // expectations queued when the stimulus was driven.
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (bus.sd_we) begin
                we_seen++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sd_we_unexpected addr=%h din=%h", bus.sd_addr, bus.sd_din);
                end else begin
                    mon_w = exp_wr.pop_front();
                    if ({bus.sd_addr, bus.sd_din} !== mon_w) begin
                        errors++;
                        $display("[TB] FAIL sd_we_order got addr=%h din=%h want addr=%h din=%h",
                                 bus.sd_addr, bus.sd_din, mon_w.addr, mon_w.data);
                    end
                end
            end
            if (bus.sd_rd) begin
                rd_seen++;
                checks++;
                if (exp_rdcmd.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sd_rd_unexpected addr=%h", bus.sd_addr);
                end else begin
                    mon_a = exp_rdcmd.pop_front();
                    if (bus.sd_addr !== mon_a) begin
                        errors++;
                        $display("[TB] FAIL sd_rd_addr got=%h want=%h", bus.sd_addr, mon_a);
                    end
                end
            end
            if (bus.sd_rd && bus.sd_we) begin
                errors++;
                $display("[TB] FAIL cmd_overlap sd_rd=1 sd_we=1 want one at a time");
            end
            if (bus.rd_valid) begin
                valid_seen++;
                checks++;
                if (exp_rdata.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rd_valid_unexpected rd_data=%h", bus.rd_data);
                end else begin
                    mon_d = exp_rdata.pop_front();
                    if (bus.rd_data !== mon_d) begin
                        errors++;
                        $display("[TB] FAIL rd_data got=%h want=%h", bus.rd_data, mon_d);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_sys);
            if (exp_wr.size() == 0 && exp_rdcmd.size() == 0 && exp_rdata.size() == 0 &&
                !bus.ld_wait && bus.sd_ready && !bus.rd_valid) begin
                done = 1;
                break;
            end
        end
        repeat (2) @(negedge clk_sys);
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s_drain got=pending want=idle wr=%0d rd=%0d data=%0d",
                     name, exp_wr.size(), exp_rdcmd.size(), exp_rdata.size());
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.ld_wr   = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({bus.ld_wait, bus.rd_valid, bus.sd_rd, bus.sd_we, bus.err_timeout} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got=%b want=00000",
                     {bus.ld_wait, bus.rd_valid, bus.sd_rd, bus.sd_we, bus.err_timeout});
        end
        checks++;
        if ({bus.sd_addr, bus.sd_din, bus.rd_data} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_buses got addr=%h din=%h rd_data=%h want 0",
                     bus.sd_addr, bus.sd_din, bus.rd_data);
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        checks++;
        if ({bus.ld_wait, bus.sd_rd, bus.sd_we, bus.rd_valid} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle got=%b want=0000",
                     {bus.ld_wait, bus.sd_rd, bus.sd_we, bus.rd_valid});
        end
    endtask

    task automatic test_read_only();
        int rd_cnt = 0;
        int cyc = 0;
        int rd_cyc = -1;
        int v_cyc = -1;
        @(negedge clk_sys);
        bus.rd_addr = AW'('h000123);
        bus.rd_req  = 1'b1;
        exp_rdcmd.push_back(AW'('h000123));
        exp_rdata.push_back(8'h5A);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            cyc++;
            if (bus.sd_rd) begin
                rd_cnt++;
                rd_cyc = cyc;
            end
            if (bus.rd_valid) begin
                v_cyc = cyc;
                bus.rd_req = 1'b0;
                break;
            end
        end
        checks++;
        if (v_cyc < 0) begin
            errors++;
            $display("[TB] FAIL read_only_valid got=none want=rd_valid within 100 cycles");
        end
        checks++;
        if (rd_cnt != 1) begin
            errors++;
            $display("[TB] FAIL read_only_sd_rd_count got=%0d want=1", rd_cnt);
        end
        // Command cycle, then LAT model cycles until ready, then one WAIT cycle.
        checks++;
        if (v_cyc - rd_cyc != LAT + 2) begin
            errors++;
            $display("[TB] FAIL read_only_latency got=%0d want=%0d", v_cyc - rd_cyc, LAT + 2);
        end
        @(negedge clk_sys);
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL read_only_hold got valid=%b data=%h want valid=0 data=5a",
                     bus.rd_valid, bus.rd_data);
        end
        wait_idle("read_only");
    endtask

    task automatic test_write_stream();
        int sent = 0;
        int cur = 0;
        int max_wait = 0;
        int we0 = we_seen;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_sys);
            if (bus.ld_wait) cur++;
            else cur = 0;
            if (cur > max_wait) max_wait = cur;
            if (sent < 20 && !bus.ld_wait) begin
                bus.ld_addr = AW'(sent);
                bus.ld_data = 8'(sent) ^ 8'hA5;
                bus.ld_wr   = 1'b1;
                exp_wr.push_back('{addr: AW'(sent), data: 8'(sent) ^ 8'hA5});
                sent++;
            end else begin
                bus.ld_wr = 1'b0;
            end
            if (sent == 20 && !bus.ld_wr && exp_wr.size() == 0) break;
        end
        bus.ld_wr = 1'b0;
        wait_idle("write_stream");
        checks++;
        if (we_seen - we0 != 20) begin
            errors++;
            $display("[TB] FAIL write_stream_count got=%0d want=20", we_seen - we0);
        end
        checks++;
        if (max_wait > LAT + 3) begin
            errors++;
            $display("[TB] FAIL write_stream_ld_wait got=%0d cycles want<=%0d", max_wait, LAT + 3);
        end
    endtask

    task automatic test_fairness();
        int wr_since = 0;
        int reads = 0;
        int next = 'h200;
        @(negedge clk_sys);
        bus.ld_addr = AW'(next);
        bus.ld_data = 8'(next) ^ 8'h5C;
        bus.ld_wr   = 1'b1;
        exp_wr.push_back('{addr: AW'(next), data: 8'(next) ^ 8'h5C});
        next++;
        @(negedge clk_sys);
        bus.ld_wr   = 1'b0;
        bus.rd_addr = AW'('h123);
        bus.rd_req  = 1'b1;
        exp_rdcmd.push_back(AW'('h123));
        exp_rdata.push_back(8'h5A);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_sys);
            if (bus.sd_we) wr_since++;
            if (bus.sd_rd) begin
                checks++;
                if (wr_since != MAX_RUN) begin
                    errors++;
                    $display("[TB] FAIL fairness_run%0d got=%0d writes want=%0d", reads, wr_since, MAX_RUN);
                end
                wr_since = 0;
                reads++;
            end
            if (bus.rd_valid) begin
                if (reads < 2) begin
                    exp_rdcmd.push_back(AW'('h123));
                    exp_rdata.push_back(8'h5A);
                end else begin
                    bus.rd_req = 1'b0;
                end
            end
            if (reads < 2 && !bus.ld_wait) begin
                bus.ld_addr = AW'(next);
                bus.ld_data = 8'(next) ^ 8'h5C;
                bus.ld_wr   = 1'b1;
                exp_wr.push_back('{addr: AW'(next), data: 8'(next) ^ 8'h5C});
                next++;
            end else begin
                bus.ld_wr = 1'b0;
            end
            if (reads == 2 && !bus.rd_req && exp_wr.size() == 0) break;
        end
        bus.ld_wr  = 1'b0;
        bus.rd_req = 1'b0;
        checks++;
        if (reads != 2) begin
            errors++;
            $display("[TB] FAIL fairness_reads got=%0d want=2", reads);
        end
        wait_idle("fairness");
    endtask

    task automatic test_collision();
        int cyc = 0;
        int rd_cyc = -1;
        int we_cyc = -1;
        int bad_wait = 0;
        @(negedge clk_sys);
        bus.ld_addr = AW'('h300);
        bus.ld_data = 8'h77;
        bus.ld_wr   = 1'b1;
        bus.rd_addr = AW'('h045);
        bus.rd_req  = 1'b1;
        exp_wr.push_back('{addr: AW'('h300), data: 8'h77});
        exp_rdcmd.push_back(AW'('h045));
        exp_rdata.push_back(model_byte(AW'('h045)));
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sys);
            cyc++;
            bus.ld_wr = 1'b0;
            if (bus.sd_rd && rd_cyc < 0) rd_cyc = cyc;
            if (bus.sd_we && we_cyc < 0) we_cyc = cyc;
            if (!bus.ld_wait) bad_wait++;
            if (bus.rd_valid) bus.rd_req = 1'b0;
            if (we_cyc >= 0) break;
        end
        checks++;
        if (rd_cyc < 0 || we_cyc <= rd_cyc) begin
            errors++;
            $display("[TB] FAIL collision_order got rd_cyc=%0d we_cyc=%0d want read first", rd_cyc, we_cyc);
        end
        checks++;
        if (bad_wait != 0) begin
            errors++;
            $display("[TB] FAIL collision_ld_wait got=%0d low cycles want=0 before write", bad_wait);
        end
        @(negedge clk_sys);
        checks++;
        if (bus.ld_wait !== 1'b0) begin
            errors++;
            $display("[TB] FAIL collision_ld_wait_clear got=%b want=0", bus.ld_wait);
        end
        wait_idle("collision");
    endtask

    task automatic test_timeout();
        int cyc = 0;
        int rd_cyc = -1;
        int v_cyc = -1;
        hang = 1'b1;
        @(negedge clk_sys);
        bus.rd_addr = AW'('h050);
        bus.rd_req  = 1'b1;
        exp_rdcmd.push_back(AW'('h050));
        exp_rdata.push_back(8'hFF);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_sys);
            cyc++;
            if (bus.sd_rd) begin
                rd_cyc = cyc;
                checks++;
                if (bus.err_timeout !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL timeout_err_early got=%b want=0", bus.err_timeout);
                end
            end
            if (bus.rd_valid) begin
                v_cyc = cyc;
                checks++;
                if (bus.err_timeout !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL timeout_err_set got=%b want=1", bus.err_timeout);
                end
                bus.rd_req = 1'b0;
                break;
            end
        end
        // ISSUE and GUARD cycles, then TMO WAIT cycles, then the rd_valid cycle.
        checks++;
        if (rd_cyc < 0 || v_cyc - rd_cyc != TMO + 2) begin
            errors++;
            $display("[TB] FAIL timeout_delay got=%0d want=%0d", v_cyc - rd_cyc, TMO + 2);
        end
        hang = 1'b0;
        wait_idle("timeout_release");
        @(negedge clk_sys);
        bus.rd_addr = AW'('h051);
        bus.rd_req  = 1'b1;
        exp_rdcmd.push_back(AW'('h051));
        exp_rdata.push_back(model_byte(AW'('h051)));
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            if (bus.rd_valid) begin
                bus.rd_req = 1'b0;
                break;
            end
        end
        bus.rd_req = 1'b0;
        wait_idle("timeout_after");
        checks++;
        if (bus.err_timeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_sticky got=%b want=1", bus.err_timeout);
        end
    endtask

    task automatic test_reset_mid_wait();
        int we0;
        int rd0;
        int v0;
        bit issued = 0;
        hang = 1'b1;
        @(negedge clk_sys);
        bus.rd_addr = AW'('h060);
        bus.rd_req  = 1'b1;
        bus.ld_addr = AW'('h400);
        bus.ld_data = 8'h11;
        bus.ld_wr   = 1'b1;
        exp_rdcmd.push_back(AW'('h060));
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_sys);
            bus.ld_wr = 1'b0;
            if (bus.sd_rd) begin
                issued = 1;
                break;
            end
        end
        repeat (3) @(negedge clk_sys);
        checks++;
        if (!issued || bus.ld_wait !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_setup got issued=%0d ld_wait=%b want 1/1", issued, bus.ld_wait);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.ld_wait, bus.rd_valid, bus.sd_rd, bus.sd_we, bus.err_timeout} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_async_flags got=%b want=00000",
                     {bus.ld_wait, bus.rd_valid, bus.sd_rd, bus.sd_we, bus.err_timeout});
        end
        checks++;
        if ({bus.sd_addr, bus.sd_din, bus.rd_data} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_async_buses got addr=%h din=%h rd_data=%h want 0",
                     bus.sd_addr, bus.sd_din, bus.rd_data);
        end
        exp_wr.delete();
        exp_rdcmd.delete();
        exp_rdata.delete();
        bus.rd_req = 1'b0;
        hang       = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        we0 = we_seen;
        rd0 = rd_seen;
        v0  = valid_seen;
        repeat (30) @(negedge clk_sys);
        checks++;
        if (we_seen != we0 || rd_seen != rd0 || valid_seen != v0 || bus.ld_wait !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_cmd got we=%0d rd=%0d valid=%0d ld_wait=%b want 0/0/0/0",
                     we_seen - we0, rd_seen - rd0, valid_seen - v0, bus.ld_wait);
        end
    endtask

    initial begin
        test_reset();
        test_read_only();
        test_write_stream();
        test_fairness();
        test_collision();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=running want=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
